// File: rtl/issue_ctrl_if.sv
// Decoder/datapath-facing bundle of the in-order issue controller.
// master = decoder + datapath side, slave = issue_ctrl.
interface issue_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       rd_addr;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic             operand_a_enable;
   logic             operand_b_enable;
   logic             rd_is_operand_a;
   logic             result_enable;
   logic             use_alu;
   logic             use_fpu;
   logic             is_load;
   logic             is_store;
   logic             is_jump;
   logic             alu_wb_valid;
   logic [4:0]       alu_wb_addr;
   logic             fpu_wb_valid;
   logic [4:0]       fpu_wb_addr;
   logic             mem_done;
   logic             issue_alu;
   logic             issue_fpu;
   logic             issue_mem;
   logic             issue_jump;
   logic [4:0]       issue_rd;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output in_valid, rd_addr, rs1_addr, rs2_addr, operand_a_enable, operand_b_enable,
             rd_is_operand_a, result_enable, use_alu, use_fpu, is_load, is_store, is_jump,
             alu_wb_valid, alu_wb_addr, fpu_wb_valid, fpu_wb_addr, mem_done,
      input  in_ready, issue_alu, issue_fpu, issue_mem, issue_jump, issue_rd, stall_cnt
   );

   modport slave (
      input  in_valid, rd_addr, rs1_addr, rs2_addr, operand_a_enable, operand_b_enable,
             rd_is_operand_a, result_enable, use_alu, use_fpu, is_load, is_store, is_jump,
             alu_wb_valid, alu_wb_addr, fpu_wb_valid, fpu_wb_addr, mem_done,
      output in_ready, issue_alu, issue_fpu, issue_mem, issue_jump, issue_rd, stall_cnt
   );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: register scoreboard, FPU/memory occupancy, jump drain.
// Optional ISSUE_BYPASS_EN: same-cycle writebacks are masked out of the hazard check.
//
// state | meaning
// RUN   | accepting instructions whenever no hazard is present
// DRAIN | jump waiting for scoreboard, FPU and memory to empty; in_ready held low
module issue_ctrl #(
   parameter int FPU_LATENCY = 4,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   issue_ctrl_if.slave bus
);
   localparam int FW = $clog2(FPU_LATENCY + 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [31:0]      pending;
   logic [31:0]      pend_chk, wb_clr, rd_set;
   logic [FW-1:0]    fpu_cnt;
   logic             mem_busy, mem_load;
   logic [4:0]       load_rd;
   logic [CNT_W-1:0] stall_q;
   logic             raw_haz, struct_haz, in_flight, jump_wait, ready, accept;
   logic             go_jump, go_mem, go_fpu, go_alu;
   logic             iss_alu, iss_fpu, iss_mem, iss_jump;
   logic [4:0]       iss_rd;

   always_comb begin
      wb_clr = '0;
      if (bus.alu_wb_valid) wb_clr[bus.alu_wb_addr] = 1'b1;
      if (bus.fpu_wb_valid) wb_clr[bus.fpu_wb_addr] = 1'b1;
      if (bus.mem_done && mem_busy && mem_load) wb_clr[load_rd] = 1'b1;
`ifdef ISSUE_BYPASS_EN
      pend_chk = pending & ~wb_clr;
`else
      pend_chk = pending;
`endif
      raw_haz = (bus.operand_a_enable && !bus.rd_is_operand_a && pend_chk[bus.rs1_addr]) ||
                ((bus.rd_is_operand_a || bus.result_enable) && pend_chk[bus.rd_addr]) ||
                (bus.operand_b_enable && pend_chk[bus.rs2_addr]);
      // Count reaches 1 on the FPU's last busy cycle, so an op accepted then issues as it frees.
      struct_haz = (bus.use_fpu && (fpu_cnt > FW'(1))) ||
                   ((bus.is_load || bus.is_store) && mem_busy);
      in_flight  = (|pending) || (fpu_cnt != '0) || mem_busy;
      jump_wait  = bus.is_jump && in_flight;
      ready      = (state_q == RUN) && !raw_haz && !struct_haz && !jump_wait;
      accept     = bus.in_valid && ready;

      go_jump = bus.is_jump;
      go_mem  = !go_jump && (bus.is_load || bus.is_store);
      go_fpu  = !go_jump && !go_mem && bus.use_fpu;
      go_alu  = !go_jump && !go_mem && !go_fpu && bus.use_alu;

      rd_set = '0;
      if (accept && (bus.result_enable || bus.is_load) && (bus.rd_addr != 5'd0))
         rd_set[bus.rd_addr] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.in_valid && jump_wait) state_d = DRAIN;
         DRAIN:   if (!in_flight) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         pending  <= '0;
         fpu_cnt  <= '0;
         mem_busy <= 1'b0;
         mem_load <= 1'b0;
         load_rd  <= '0;
         stall_q  <= '0;
         iss_alu  <= 1'b0;
         iss_fpu  <= 1'b0;
         iss_mem  <= 1'b0;
         iss_jump <= 1'b0;
         iss_rd   <= '0;
      end else begin
         state_q <= state_d;
         pending <= (pending & ~wb_clr) | rd_set;

         if (accept && go_fpu)       fpu_cnt <= FW'(FPU_LATENCY);
         else if (fpu_cnt != '0)     fpu_cnt <= fpu_cnt - FW'(1);

         if (accept && go_mem) begin
            mem_busy <= 1'b1;
            mem_load <= bus.is_load;
            load_rd  <= bus.rd_addr;
         end else if (bus.mem_done) begin
            mem_busy <= 1'b0;
         end

         if (bus.in_valid && !ready && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);

         iss_alu  <= accept && go_alu;
         iss_fpu  <= accept && go_fpu;
         iss_mem  <= accept && go_mem;
         iss_jump <= accept && go_jump;
         iss_rd   <= accept ? bus.rd_addr : 5'd0;
      end
   end

   assign bus.in_ready   = ready;
   assign bus.issue_alu  = iss_alu;
   assign bus.issue_fpu  = iss_fpu;
   assign bus.issue_mem  = iss_mem;
   assign bus.issue_jump = iss_jump;
   assign bus.issue_rd   = iss_rd;
   assign bus.stall_cnt  = stall_q;
endmodule
